// File: rtl/dbus_bridge_pkg.sv
// rtl/dbus_bridge_pkg.sv - shared types and constants for the data-bus bridge
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_WB,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    REG_MEM,
    REG_RSA,
    REG_NONE
  } region_t;

  localparam int          DEF_MEM_BYTES = 32768;
  localparam logic [31:0] DEF_RSA_BASE  = 32'h4000_0000;
  localparam logic [31:0] DEF_RSA_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] ERR_RDATA     = 32'h0;

endpackage

// File: rtl/dbus_bridge_if.sv
// rtl/dbus_bridge_if.sv - CPU, data-memory and Wishbone signals seen by the bridge
interface dbus_bridge_if;

  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  // slave: the bridge itself; master: the CPU plus both targets around it
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_we, mem_rdata, wb_dat_i, wb_ack_i,
    output cpu_rdata, cpu_ready, cpu_err, mem_en, mem_addr, mem_wdata, mem_we,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_we, mem_rdata, wb_dat_i, wb_ack_i,
    input  cpu_rdata, cpu_ready, cpu_err, mem_en, mem_addr, mem_wdata, mem_we,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

endinterface

// File: rtl/dbus_bridge_addr_decode.sv
// rtl/dbus_bridge_addr_decode.sv - combinational byte address to target region decoder
module dbus_addr_decode
  import dbus_pkg::*;
#(
  parameter int          MEM_BYTES = DEF_MEM_BYTES,
  parameter logic [31:0] RSA_BASE  = DEF_RSA_BASE,
  parameter logic [31:0] RSA_MASK  = DEF_RSA_MASK
) (
  input  logic [31:0] i_addr,
  output region_t     o_region
);

  always_comb begin
    o_region = REG_NONE;
    if (i_addr < 32'(MEM_BYTES)) begin
      o_region = REG_MEM;
    end else if ((i_addr & RSA_MASK) == RSA_BASE) begin
      o_region = REG_RSA;
    end
  end

endmodule

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - routes CPU loads/stores to data memory or the Wishbone RSA window
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int          MEM_BYTES   = DEF_MEM_BYTES,
  parameter logic [31:0] RSA_BASE    = DEF_RSA_BASE,
  parameter logic [31:0] RSA_MASK    = DEF_RSA_MASK,
  parameter int          MEM_LATENCY = 1,
  parameter int          WB_TIMEOUT  = 16
) (
  input logic          clk,
  input logic          rst,
  dbus_bridge_if.slave bus
);

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;
  logic [3:0]  r_we, w_we;
  logic [31:0] r_cpu_rdata, w_cpu_rdata;
  logic        r_cpu_ready, w_cpu_ready;
  logic        r_cpu_err, w_cpu_err;
  logic        r_mem_en, w_mem_en;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic [31:0] r_mem_wdata, w_mem_wdata;
  logic [3:0]  r_mem_we, w_mem_we;
  logic        r_wb_cyc, w_wb_cyc;
  logic        r_wb_we, w_wb_we;
  logic [3:0]  r_wb_sel, w_wb_sel;
  logic [31:0] r_wb_adr, w_wb_adr;
  logic [31:0] r_wb_dat, w_wb_dat;
  region_t     w_region;

  dbus_addr_decode #(
    .MEM_BYTES (MEM_BYTES),
    .RSA_BASE  (RSA_BASE),
    .RSA_MASK  (RSA_MASK)
  ) u_decode (
    .i_addr   (bus.cpu_addr),
    .o_region (w_region)
  );

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_we        = r_we;
    w_cpu_rdata = ERR_RDATA;
    w_cpu_ready = 1'b0;
    w_cpu_err   = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_we    = 4'h0;
    w_wb_cyc    = r_wb_cyc;
    w_wb_we     = r_wb_we;
    w_wb_sel    = r_wb_sel;
    w_wb_adr    = r_wb_adr;
    w_wb_dat    = r_wb_dat;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          w_we = bus.cpu_we;
          case (w_region)
            REG_MEM: begin
              w_state     = ST_MEM;
              w_cnt       = 16'(MEM_LATENCY);
              w_mem_en    = 1'b1;
              w_mem_we    = bus.cpu_we;
              w_mem_addr  = bus.cpu_addr;
              w_mem_wdata = bus.cpu_wdata;
            end
            REG_RSA: begin
              w_state  = ST_WB;
              w_cnt    = 16'd0;
              w_wb_cyc = 1'b1;
              w_wb_we  = |bus.cpu_we;
              w_wb_sel = (|bus.cpu_we) ? bus.cpu_we : 4'hF;
              w_wb_adr = bus.cpu_addr;
              w_wb_dat = bus.cpu_wdata;
            end
            default: begin
              w_state     = ST_RESP;
              w_cpu_ready = 1'b1;
              w_cpu_err   = 1'b1;
            end
          endcase
        end
      end
      ST_MEM: begin
        // counter reaching zero means mem_rdata is valid on this edge
        if (r_cnt == 16'd0) begin
          w_cpu_rdata = (r_we == 4'h0) ? bus.mem_rdata : ERR_RDATA;
          w_cpu_ready = 1'b1;
          w_state     = ST_RESP;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end
      ST_WB: begin
        if (bus.wb_ack_i) begin
          w_cpu_rdata = r_wb_we ? ERR_RDATA : bus.wb_dat_i;
          w_cpu_ready = 1'b1;
          w_wb_cyc    = 1'b0;
          w_state     = ST_RESP;
        end else if (r_cnt == 16'(WB_TIMEOUT - 1)) begin
          w_cpu_ready = 1'b1;
          w_cpu_err   = 1'b1;
          w_wb_cyc    = 1'b0;
          w_state     = ST_RESP;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      ST_RESP: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_we        <= 4'h0;
      r_cpu_rdata <= 32'h0;
      r_cpu_ready <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_we    <= 4'h0;
      r_wb_cyc    <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_sel    <= 4'h0;
      r_wb_adr    <= 32'h0;
      r_wb_dat    <= 32'h0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_we        <= w_we;
      r_cpu_rdata <= w_cpu_rdata;
      r_cpu_ready <= w_cpu_ready;
      r_cpu_err   <= w_cpu_err;
      r_mem_en    <= w_mem_en;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_we    <= w_mem_we;
      r_wb_cyc    <= w_wb_cyc;
      r_wb_we     <= w_wb_we;
      r_wb_sel    <= w_wb_sel;
      r_wb_adr    <= w_wb_adr;
      r_wb_dat    <= w_wb_dat;
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ready = r_cpu_ready;
  assign bus.cpu_err   = r_cpu_err;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.wb_cyc_o  = r_wb_cyc;
  assign bus.wb_stb_o  = r_wb_cyc;
  assign bus.wb_we_o   = r_wb_we;
  assign bus.wb_sel_o  = r_wb_sel;
  assign bus.wb_adr_o  = r_wb_adr;
  assign bus.wb_dat_o  = r_wb_dat;

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - directed self-checking bench for dbus_bridge
module tb_dbus_bridge;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_cyc;

  dbus_bridge_if bus ();

  dbus_bridge dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_we    = we;
  endtask

  // counts cycles with wb_cyc_o high, acking in cycle ack_at (0 = never); bounded
  task automatic run_wb(input int ack_at, input logic [31:0] dat, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.wb_cyc_o) break;
      n++;
      bus.wb_ack_i = (n == ack_at);
      bus.wb_dat_i = (n == ack_at) ? dat : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    bus.wb_ack_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_we    = 4'h0;
    bus.mem_rdata = 32'h0;
    bus.wb_dat_i  = 32'h0;
    bus.wb_ack_i  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, bus.cpu_ready}, 32'h0);
    chk("rst_err", {31'h0, bus.cpu_err}, 32'h0);
    chk("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("rst_wb_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("rst_wb_sel", {28'h0, bus.wb_sel_o}, 32'h0);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: memory load
    issue(32'h10, 32'h0, 4'h0);
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t1_mem_en", {31'h0, bus.mem_en}, 32'h1);
    chk("t1_mem_addr", bus.mem_addr, 32'h10);
    chk("t1_mem_we", {28'h0, bus.mem_we}, 32'h0);
    chk("t1_ready_early", {31'h0, bus.cpu_ready}, 32'h0);
    @(negedge clk);
    chk("t1_mem_en_drop", {31'h0, bus.mem_en}, 32'h0);
    chk("t1_ready_early2", {31'h0, bus.cpu_ready}, 32'h0);
    @(negedge clk);
    chk("t1_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("t1_rdata", bus.cpu_rdata, 32'h1234_5678);
    chk("t1_err", {31'h0, bus.cpu_err}, 32'h0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t1_ready_off", {31'h0, bus.cpu_ready}, 32'h0);
    chk("t1_rdata_off", bus.cpu_rdata, 32'h0);

    // 2: Wishbone store acked in 3rd cycle
    issue(32'h4000_0004, 32'h0000_A5A5, 4'hF);
    @(negedge clk);
    chk("t2_we", {31'h0, bus.wb_we_o}, 32'h1);
    chk("t2_sel", {28'h0, bus.wb_sel_o}, 32'hF);
    chk("t2_dat", bus.wb_dat_o, 32'h0000_A5A5);
    chk("t2_adr", bus.wb_adr_o, 32'h4000_0004);
    chk("t2_stb", {31'h0, bus.wb_stb_o}, 32'h1);
    chk("t2_no_mem_en", {31'h0, bus.mem_en}, 32'h0);
    run_wb(3, 32'h5555_AAAA, n_cyc);
    chk("t2_cyc_len", n_cyc, 32'd3);
    chk("t2_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("t2_err", {31'h0, bus.cpu_err}, 32'h0);
    chk("t2_rdata", bus.cpu_rdata, 32'h0);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // 3: Wishbone load that times out
    issue(32'h4000_0008, 32'h0, 4'h0);
    @(negedge clk);
    chk("t3_sel", {28'h0, bus.wb_sel_o}, 32'hF);
    chk("t3_we", {31'h0, bus.wb_we_o}, 32'h0);
    run_wb(0, 32'h0, n_cyc);
    chk("t3_cyc_len", n_cyc, 32'd16);
    chk("t3_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("t3_err", {31'h0, bus.cpu_err}, 32'h1);
    chk("t3_rdata", bus.cpu_rdata, 32'h0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t3_err_off", {31'h0, bus.cpu_err}, 32'h0);

    // 4: unmapped load, then a back-to-back memory load
    issue(32'h8000_0000, 32'h0, 4'h0);
    @(negedge clk);
    chk("t4_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("t4_err", {31'h0, bus.cpu_err}, 32'h1);
    chk("t4_mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("t4_wb_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    issue(32'h30, 32'h0, 4'h0);
    bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("t4b_idle", {31'h0, bus.mem_en}, 32'h0);
    @(negedge clk);
    chk("t4b_mem_en", {31'h0, bus.mem_en}, 32'h1);
    chk("t4b_mem_addr", bus.mem_addr, 32'h30);
    repeat (2) @(negedge clk);
    chk("t4b_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("t4b_rdata", bus.cpu_rdata, 32'h0BAD_F00D);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // 5: reset in the 5th WB cycle, then a normal memory load
    issue(32'h4000_0010, 32'h0, 4'h0);
    repeat (5) @(negedge clk);
    chk("t5_cyc_before", {31'h0, bus.wb_cyc_o}, 32'h1);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("t5_cyc_clear", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("t5_stb_clear", {31'h0, bus.wb_stb_o}, 32'h0);
    chk("t5_adr_clear", bus.wb_adr_o, 32'h0);
    chk("t5_sel_clear", {28'h0, bus.wb_sel_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_resp", {31'h0, bus.cpu_ready}, 32'h0);
    issue(32'h20, 32'h0, 4'h0);
    bus.mem_rdata = 32'h2020_2020;
    @(negedge clk);
    chk("t5_mem_addr", bus.mem_addr, 32'h20);
    repeat (2) @(negedge clk);
    chk("t5_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("t5_rdata", bus.cpu_rdata, 32'h2020_2020);
    chk("t5_err", {31'h0, bus.cpu_err}, 32'h0);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // 6: ack in the final timeout cycle wins
    issue(32'h4000_000C, 32'h0, 4'h0);
    @(negedge clk);
    run_wb(16, 32'hCAFE_0001, n_cyc);
    chk("t6_cyc_len", n_cyc, 32'd16);
    chk("t6_ready", {31'h0, bus.cpu_ready}, 32'h1);
    chk("t6_err", {31'h0, bus.cpu_err}, 32'h0);
    chk("t6_rdata", bus.cpu_rdata, 32'hCAFE_0001);
    bus.cpu_req = 1'b0;
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("t6_late_ack", {31'h0, bus.cpu_ready}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
